// File: rtl/button_debounce.sv
// Per-channel button debouncer: two-flop synchroniser, then a stability counter.
// A channel's level is accepted only after it has disagreed with the debounced state for STABLE_CYCLES edges.
module button_debounce #(
    parameter int WIDTH         = 1,
    parameter int STABLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int CW = ($clog2(STABLE_CYCLES + 1) < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        logic [CW-1:0] r_cnt;
        logic          r_state;
        logic          r_rise;
        logic          r_fall;
        logic          w_diff;
        logic          w_accept;

        assign w_diff   = r_sync2[g] ^ r_state;
        assign w_accept = w_diff && (r_cnt == LAST);

        // Counter clears whenever the synchronised level agrees with state, so a glitch restarts the count.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt   <= '0;
                r_state <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_rise <= w_accept && r_sync2[g];
                r_fall <= w_accept && !r_sync2[g];
                if (!w_diff || w_accept) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                if (w_accept) begin
                    r_state <= r_sync2[g];
                end
            end
        end

        assign state[g] = r_state;
        assign rise[g]  = r_rise;
        assign fall[g]  = r_fall;
    end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: a 2-channel/4-cycle instance and a 1-channel/1-cycle instance.
module tb_button_debounce;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic [1:0] r;
        logic [1:0] f;
    } exp_t;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         passes = 0;

    logic       rst_a = 1'b0;
    logic [1:0] in_a  = 2'b00;
    logic [1:0] state_a, rise_a, fall_a;

    logic       rst_b = 1'b0;
    logic [0:0] in_b  = 1'b0;
    logic [0:0] state_b, rise_b, fall_b;

    exp_t qa[$];
    exp_t qb[$];

    button_debounce #(.WIDTH(2), .STABLE_CYCLES(4)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .in    (in_a),
        .state (state_a),
        .rise  (rise_a),
        .fall  (fall_a)
    );

    button_debounce #(.WIDTH(1), .STABLE_CYCLES(1)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .in    (in_b),
        .state (state_b),
        .rise  (rise_b),
        .fall  (fall_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_cyc(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    function automatic void push_a(input int c, input logic [1:0] s, input logic [1:0] r, input logic [1:0] f);
        exp_t e;
        e.cyc = c; e.st = s; e.r = r; e.f = f;
        qa.push_back(e);
    endfunction

    function automatic void push_b(input int c, input logic s, input logic r, input logic f);
        exp_t e;
        e.cyc = c; e.st = {1'b0, s}; e.r = {1'b0, r}; e.f = {1'b0, f};
        qb.push_back(e);
    endfunction

    // Scheduled expectations are compared on their cycle; every other cycle must be pulse-free.
    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0 && qa[0].cyc <= cyc) begin
            e = qa.pop_front();
            checks++;
            if (e.cyc == cyc && state_a == e.st && rise_a == e.r && fall_a == e.f) passes++;
            else $display("FAIL a_sched cyc=%0d(req %0d) actual state=%b rise=%b fall=%b required state=%b rise=%b fall=%b",
                          cyc, e.cyc, state_a, rise_a, fall_a, e.st, e.r, e.f);
        end else if (cyc > 0) begin
            checks++;
            if (rise_a == 2'b00 && fall_a == 2'b00) passes++;
            else $display("FAIL a_quiet cyc=%0d actual rise=%b fall=%b required rise=00 fall=00", cyc, rise_a, fall_a);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (qb.size() > 0 && qb[0].cyc <= cyc) begin
            e = qb.pop_front();
            checks++;
            if (e.cyc == cyc && state_b == e.st[0] && rise_b == e.r[0] && fall_b == e.f[0]) passes++;
            else $display("FAIL b_sched cyc=%0d(req %0d) actual state=%b rise=%b fall=%b required state=%b rise=%b fall=%b",
                          cyc, e.cyc, state_b, rise_b, fall_b, e.st[0], e.r[0], e.f[0]);
        end else if (cyc > 0) begin
            checks++;
            if (rise_b == 1'b0 && fall_b == 1'b0) passes++;
            else $display("FAIL b_quiet cyc=%0d actual rise=%b fall=%b required rise=0 fall=0", cyc, rise_b, fall_b);
        end
    end

    task automatic run_a();
        push_a(1, 2'b00, 2'b00, 2'b00);
        push_a(3, 2'b00, 2'b00, 2'b00);
        wait_cyc(3);
        rst_a = 1'b1;
        push_a(13, 2'b00, 2'b00, 2'b00);
        push_a(23, 2'b00, 2'b00, 2'b00);
        // single channel rise, then fall
        wait_cyc(25);
        in_a = 2'b01;
        push_a(30, 2'b00, 2'b00, 2'b00);
        push_a(31, 2'b01, 2'b01, 2'b00);
        push_a(32, 2'b01, 2'b00, 2'b00);
        wait_cyc(40);
        in_a = 2'b00;
        push_a(46, 2'b00, 2'b00, 2'b01);
        // three-cycle glitch is rejected
        wait_cyc(50);
        in_a = 2'b01;
        wait_cyc(53);
        in_a = 2'b00;
        push_a(60, 2'b00, 2'b00, 2'b00);
        // four-cycle pulse is the shortest accepted
        wait_cyc(62);
        in_a = 2'b01;
        wait_cyc(66);
        in_a = 2'b00;
        push_a(68, 2'b01, 2'b01, 2'b00);
        push_a(72, 2'b00, 2'b00, 2'b01);
        // both channels together
        wait_cyc(80);
        in_a = 2'b11;
        push_a(86, 2'b11, 2'b11, 2'b00);
        push_a(87, 2'b11, 2'b00, 2'b00);
        wait_cyc(95);
        in_a = 2'b00;
        push_a(101, 2'b00, 2'b00, 2'b11);
        // reset mid-count discards the count
        wait_cyc(110);
        in_a = 2'b10;
        wait_cyc(114);
        rst_a = 1'b0;
        push_a(115, 2'b00, 2'b00, 2'b00);
        wait_cyc(115);
        rst_a = 1'b1;
        push_a(116, 2'b00, 2'b00, 2'b00);
        push_a(120, 2'b00, 2'b00, 2'b00);
        push_a(121, 2'b10, 2'b10, 2'b00);
        wait_cyc(125);
        in_a = 2'b00;
        push_a(131, 2'b00, 2'b00, 2'b10);
    endtask

    task automatic run_b();
        push_b(2, 1'b0, 1'b0, 1'b0);
        wait_cyc(3);
        rst_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_cyc(10 + 4 * i);
            in_b = ~in_b;
            push_b(13 + 4 * i, in_b[0], in_b[0], ~in_b[0]);
        end
    endtask

    initial begin
        fork
            run_a();
            run_b();
        join
        wait_cyc(145);
        checks++;
        if (qa.size() == 0 && qb.size() == 0) passes++;
        else $display("FAIL queues_drained actual a=%0d b=%0d required a=0 b=0", qa.size(), qb.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
